// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the RX deserializer and the TX serializer:
// parity encodings, receiver FSM states and small bit helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE0 = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_EVEN  = 2'b10,
    PAR_NONE3 = 2'b11
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } rx_state_t;

  function automatic logic parity_enabled(input parity_t p);
    return (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sipo_if.sv
// Serial line, frame configuration and parallel result/status of the UART receiver.
interface uart_rx_sipo_if;

  logic       data_tx;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_length;
  logic [7:0] data_parll;
  logic       rx_active;
  logic       rx_done;
  logic       parity_error;
  logic       stop_error;

  modport master (
    output data_tx, parity_type, stop_bits, data_length,
    input  data_parll, rx_active, rx_done, parity_error, stop_error
  );

  modport slave (
    input  data_tx, parity_type, stop_bits, data_length,
    output data_parll, rx_active, rx_done, parity_error, stop_error
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_sipo.sv
// UART receive deserializer: majority-voted oversampling, 7/8 data bits LSB-first,
// optional parity, 1/2 stop bits, registered parallel word and status flags.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input logic           baud_out,
  input logic           rst,
  uart_rx_sipo_if.slave rx_if
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] MID_LO    = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] MID       = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] MID_HI    = TW'(OVERSAMPLE / 2 + 1);

  rx_state_t     state;
  logic [TW-1:0] tick;
  logic [3:0]    bit_cnt;
  logic [1:0]    stop_cnt;
  logic [7:0]    shift_reg;
  logic          samp_a;
  logic          samp_b;
  logic          armed;
  parity_t       cfg_parity;
  logic          cfg_stop;
  logic          cfg_len;
  logic          par_err;
  logic          stop_flag;
  logic [7:0]    data_parll_r;
  logic          rx_active_r;
  logic          rx_done_r;
  logic          parity_error_r;
  logic          stop_error_r;
  logic          rx_s;
  logic          at_decision;
  logic          bit_val;
  logic          last_data;
  logic          last_stop;

  uart_rx_sync u_sync (
    .clk (baud_out),
    .rst (rst),
    .d   (rx_if.data_tx),
    .q   (rx_s)
  );

  assign at_decision = (tick == MID_HI);
  assign bit_val     = majority3(samp_a, samp_b, rx_s);
  assign last_data   = (bit_cnt == (cfg_len ? 4'd7 : 4'd6));
  assign last_stop   = (stop_cnt == {1'b0, cfg_stop});

  // A start edge only counts once the line has been seen high in IDLE, so a held break
  // produces exactly one errored frame instead of a stream of them.
  always_ff @(posedge baud_out or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      tick           <= '0;
      bit_cnt        <= '0;
      stop_cnt       <= '0;
      shift_reg      <= '0;
      samp_a         <= 1'b0;
      samp_b         <= 1'b0;
      armed          <= 1'b0;
      cfg_parity     <= PAR_NONE0;
      cfg_stop       <= 1'b0;
      cfg_len        <= 1'b0;
      par_err        <= 1'b0;
      stop_flag      <= 1'b0;
      data_parll_r   <= '0;
      rx_active_r    <= 1'b0;
      rx_done_r      <= 1'b0;
      parity_error_r <= 1'b0;
      stop_error_r   <= 1'b0;
    end else begin
      rx_done_r <= 1'b0;
      if (state != ST_IDLE) tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
      if (tick == MID_LO) samp_a <= rx_s;
      if (tick == MID) samp_b <= rx_s;

      case (state)
        ST_IDLE: begin
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state       <= ST_START;
            tick        <= '0;
            armed       <= 1'b0;
            cfg_parity  <= parity_t'(rx_if.parity_type);
            cfg_stop    <= rx_if.stop_bits;
            cfg_len     <= rx_if.data_length;
            bit_cnt     <= '0;
            stop_cnt    <= '0;
            shift_reg   <= '0;
            par_err     <= 1'b0;
            stop_flag   <= 1'b0;
            rx_active_r <= 1'b1;
          end
        end
        ST_START: begin
          if (at_decision) begin
            if (bit_val) begin
              state       <= ST_IDLE;
              rx_active_r <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (at_decision) begin
            shift_reg[bit_cnt[2:0]] <= bit_val;
            bit_cnt                 <= bit_cnt + 4'd1;
            if (last_data) state <= parity_enabled(cfg_parity) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (at_decision) begin
            par_err <= ((^shift_reg) ^ bit_val) != (cfg_parity == PAR_ODD);
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          // The frame is handed over at the last stop decision, not at the end of the
          // stop bit, leaving slack to catch a back-to-back start edge.
          if (at_decision) begin
            if (last_stop) begin
              state          <= ST_DONE;
              rx_done_r      <= 1'b1;
              data_parll_r   <= shift_reg;
              parity_error_r <= par_err;
              stop_error_r   <= stop_flag | ~bit_val;
              rx_active_r    <= 1'b0;
            end else begin
              stop_flag <= stop_flag | ~bit_val;
              stop_cnt  <= stop_cnt + 2'd1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rx_if.data_parll   = data_parll_r;
  assign rx_if.rx_active    = rx_active_r;
  assign rx_if.rx_done      = rx_done_r;
  assign rx_if.parity_error = parity_error_r;
  assign rx_if.stop_error   = stop_error_r;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Self-checking bench for uart_rx_sipo: directed frames plus randomized frames scored
// against a frame-level reference model (expected word and flags per transmitted frame).
module tb_uart_rx_sipo;

  localparam int OS = 16;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
  } exp_t;

  logic baud_out = 1'b0;
  logic rst      = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   exp_count = 0;
  logic prev_done = 1'b0;
  logic saw_active = 1'b0;
  exp_t exp_q[$];
  exp_t last_exp;

  uart_rx_sipo_if rx_bus ();

  uart_rx_sipo #(.OVERSAMPLE(OS)) dut (
    .baud_out (baud_out),
    .rst      (rst),
    .rx_if    (rx_bus)
  );

  always #5 baud_out = ~baud_out;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every completed frame is scored against the oldest outstanding prediction.
  always @(negedge baud_out) begin
    if (rx_bus.rx_active) saw_active = 1'b1;
    if (rx_bus.rx_done) begin
      exp_t e;
      done_cnt++;
      checkOutput("done_pulse_width", {31'd0, prev_done}, 32'd0);
      checkOutput("active_low_at_done", {31'd0, rx_bus.rx_active}, 32'd0);
      checkOutput("frame_pending", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        last_exp = e;
        checkOutput("data_parll", {24'd0, rx_bus.data_parll}, {24'd0, e.data});
        checkOutput("parity_error", {31'd0, rx_bus.parity_error}, {31'd0, e.perr});
        checkOutput("stop_error", {31'd0, rx_bus.stop_error}, {31'd0, e.serr});
      end
    end
    prev_done = rx_bus.rx_done;
  end

  task automatic idle_bits(input int n);
    rx_bus.data_tx = 1'b1;
    if (n > 0) begin
      repeat (n * OS) @(posedge baud_out);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic len8, input logic [1:0] par,
                               input logic two_stop, input logic flip, input logic [1:0] stop_v,
                               input logic scramble);
    logic [15:0] frame;
    int          n;
    exp_t        e;
    logic [7:0]  d;
    logic        pbit;
    logic        par_on;
    d      = len8 ? data : {1'b0, data[6:0]};
    par_on = (par == 2'b01) || (par == 2'b10);
    frame  = '0;
    n      = 1;
    for (int i = 0; i < (len8 ? 8 : 7); i++) begin
      frame[n] = d[i];
      n++;
    end
    pbit = ((($countones(d) % 2) == 1) ^ (par == 2'b01)) ^ flip;
    if (par_on) begin
      frame[n] = pbit;
      n++;
    end
    frame[n] = stop_v[0];
    n++;
    if (two_stop) begin
      frame[n] = stop_v[1];
      n++;
    end
    e.data = d;
    e.perr = par_on && ((($countones(d) + int'(pbit)) % 2) != ((par == 2'b01) ? 1 : 0));
    e.serr = !stop_v[0] || (two_stop && !stop_v[1]);
    exp_q.push_back(e);
    rx_bus.parity_type = par;
    rx_bus.stop_bits   = two_stop;
    rx_bus.data_length = len8;
    for (int i = 0; i < n; i++) begin
      rx_bus.data_tx = frame[i];
      repeat (OS) @(posedge baud_out);
      #1;
      if (i == 0 && scramble) begin
        rx_bus.parity_type = 2'($urandom);
        rx_bus.stop_bits   = 1'($urandom);
        rx_bus.data_length = 1'($urandom);
      end
    end
  endtask

  task automatic wait_done(input int target);
    int budget;
    budget = 600;
    while (done_cnt < target && budget > 0) begin
      @(posedge baud_out);
      #1;
      budget--;
    end
    checkOutput("done_count", done_cnt, target);
  endtask

  task automatic check_held(input string tag);
    checkOutput({tag, "_data"}, {24'd0, rx_bus.data_parll}, {24'd0, last_exp.data});
    checkOutput({tag, "_perr"}, {31'd0, rx_bus.parity_error}, {31'd0, last_exp.perr});
    checkOutput({tag, "_serr"}, {31'd0, rx_bus.stop_error}, {31'd0, last_exp.serr});
  endtask

  initial begin
    logic [1:0] sv;
    logic       ts;
    int         gap;
    rx_bus.data_tx     = 1'b1;
    rx_bus.parity_type = 2'b00;
    rx_bus.stop_bits   = 1'b0;
    rx_bus.data_length = 1'b1;
    last_exp = '{data: 8'h00, perr: 1'b0, serr: 1'b0};
    repeat (3) @(posedge baud_out);
    #1;
    checkOutput("reset_rx_active", {31'd0, rx_bus.rx_active}, 32'd0);
    checkOutput("reset_rx_done", {31'd0, rx_bus.rx_done}, 32'd0);
    check_held("reset");
    rst = 1'b1;
    idle_bits(1);

    $display("[TB] 8N1 0xA5");
    applyStimulus(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    exp_count++;
    wait_done(exp_count);

    $display("[TB] 7E2 0x35 good and bad parity");
    applyStimulus(8'h35, 1'b0, 2'b10, 1'b1, 1'b0, 2'b11, 1'b0);
    exp_count++;
    wait_done(exp_count);
    applyStimulus(8'h35, 1'b0, 2'b10, 1'b1, 1'b1, 2'b11, 1'b0);
    exp_count++;
    wait_done(exp_count);

    $display("[TB] start glitch");
    idle_bits(1);
    saw_active = 1'b0;
    rx_bus.data_tx = 1'b0;
    repeat (4) @(posedge baud_out);
    #1;
    rx_bus.data_tx = 1'b1;
    repeat (40) @(posedge baud_out);
    #1;
    checkOutput("glitch_no_done", done_cnt, exp_count);
    checkOutput("glitch_active_seen", {31'd0, saw_active}, 32'd1);
    checkOutput("glitch_active_now", {31'd0, rx_bus.rx_active}, 32'd0);
    check_held("glitch");

    $display("[TB] 8N1 0x3C with bad stop bit");
    applyStimulus(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    exp_count++;
    wait_done(exp_count);
    idle_bits(2);

    $display("[TB] break condition");
    applyStimulus(8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    exp_count++;
    repeat (3 * OS) @(posedge baud_out);
    #1;
    checkOutput("break_single_done", done_cnt, exp_count);
    idle_bits(2);

    $display("[TB] reset during data bit 3");
    rx_bus.parity_type = 2'b00;
    rx_bus.stop_bits   = 1'b0;
    rx_bus.data_length = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_bus.data_tx = (i == 2) ? 1'b1 : 1'b0;
      repeat (OS) @(posedge baud_out);
      #1;
    end
    rx_bus.data_tx = 1'b1;
    repeat (OS / 2) @(posedge baud_out);
    #1;
    checkOutput("pre_reset_active", {31'd0, rx_bus.rx_active}, 32'd1);
    rst = 1'b0;
    #1;
    last_exp = '{data: 8'h00, perr: 1'b0, serr: 1'b0};
    checkOutput("midreset_rx_active", {31'd0, rx_bus.rx_active}, 32'd0);
    check_held("midreset");
    repeat (3) @(posedge baud_out);
    #1;
    rst = 1'b1;
    idle_bits(1);
    applyStimulus(8'h81, 1'b1, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    exp_count++;
    wait_done(exp_count);

    $display("[TB] back-to-back 0x00 then 0xFF");
    applyStimulus(8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    exp_count++;
    applyStimulus(8'hFF, 1'b1, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    exp_count++;
    wait_done(exp_count);
    idle_bits(1);

    $display("[TB] randomized frames");
    for (int k = 0; k < 24; k++) begin
      sv[0] = ($urandom_range(0, 4) != 0);
      sv[1] = ($urandom_range(0, 4) != 0);
      ts    = 1'($urandom);
      applyStimulus(8'($urandom), 1'($urandom), 2'($urandom), ts,
                    ($urandom_range(0, 3) == 0), sv, 1'b1);
      exp_count++;
      wait_done(exp_count);
      gap = ((ts ? sv[1] : sv[0]) == 1'b0) ? 1 + $urandom_range(0, 1) : $urandom_range(0, 1);
      idle_bits(gap);
    end
    idle_bits(2);
    checkOutput("final_done_count", done_cnt, exp_count);
    checkOutput("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
